composition_if_ctrl: RTL and testbench

//  Sequencer for the conditional composition IF(p, f, g)(x1,x2,x3).

---
 rtl/composition_if_ctrl.sv | 179 +++++++++++++++++
 tb/tb_composition_if_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/composition_if_ctrl.sv
// Sequencer for IF(p, f, g): runs predicate p, then exactly one of f / g, over ST/RD/RES handshakes.
// Optional watchdog on both wait phases is enabled by defining COMPOSITION_IF_TIMEOUT_EN.
module composition_if_ctrl #(
  parameter int W   = 16,
  parameter int TMO = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  output logic         RD,
  output logic [W-1:0] RES,
  input  logic [W-1:0] IN1,
  input  logic [W-1:0] IN2,
  input  logic [W-1:0] IN3,
  output logic [W-1:0] ARG1,
  output logic [W-1:0] ARG2,
  output logic [W-1:0] ARG3,
  output logic         P_ST,
  input  logic         P_RD,
  input  logic [W-1:0] P_RES,
  output logic         T_ST,
  input  logic         T_RD,
  input  logic [W-1:0] T_RES,
  output logic         E_ST,
  input  logic         E_RD,
  input  logic [W-1:0] E_RES,
  output logic         COND,
  output logic         ERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_P_ISS  = 3'd1,
    S_P_WAIT = 3'd2,
    S_B_ISS  = 3'd3,
    S_B_WAIT = 3'd4
  } state_t;

  state_t         r_state;
  logic           r_rd;
  logic [W-1:0]   r_res;
  logic [W-1:0]   r_arg1;
  logic [W-1:0]   r_arg2;
  logic [W-1:0]   r_arg3;
  logic           r_p_st;
  logic           r_t_st;
  logic           r_e_st;
  logic           r_cond;

  logic           w_p_true;
  logic           w_br_rd;
  logic [W-1:0]   w_br_res;
  logic           w_waiting;
  logic           w_tmo;

  assign w_p_true  = (P_RES != '0);
  // r_cond already holds this run's predicate outcome while in B_WAIT.
  assign w_br_rd   = r_cond ? T_RD  : E_RD;
  assign w_br_res  = r_cond ? T_RES : E_RES;
  assign w_waiting = ((r_state == S_P_WAIT) && !P_RD) ||
                     ((r_state == S_B_WAIT) && !w_br_rd);

`ifdef COMPOSITION_IF_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  logic [15:0] r_wdog;
  logic        r_err;

  assign w_tmo = w_waiting && (r_wdog == TMO_LAST);
  assign ERR   = r_err;

  // Counter restarts on each issue state so both wait phases get the full TMO budget.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == S_P_ISS) || (r_state == S_B_ISS)) begin
        r_wdog <= '0;
      end else if (w_waiting) begin
        r_wdog <= r_wdog + 16'd1;
      end
      if ((r_state == S_IDLE) && ST && r_rd) begin
        r_err <= 1'b0;
      end else if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_tmo = 1'b0;
  assign ERR   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_rd    <= 1'b1;
      r_res   <= '0;
      r_arg1  <= '0;
      r_arg2  <= '0;
      r_arg3  <= '0;
      r_p_st  <= 1'b0;
      r_t_st  <= 1'b0;
      r_e_st  <= 1'b0;
      r_cond  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ST && r_rd) begin
            r_arg1  <= IN1;
            r_arg2  <= IN2;
            r_arg3  <= IN3;
            r_rd    <= 1'b0;
            r_p_st  <= 1'b1;
            r_state <= S_P_ISS;
          end
        end
        // Callee drops its RD on this edge, so P_RD is only meaningful from P_WAIT on.
        S_P_ISS: begin
          r_p_st  <= 1'b0;
          r_state <= S_P_WAIT;
        end
        S_P_WAIT: begin
          if (P_RD) begin
            r_cond  <= w_p_true;
            r_t_st  <= w_p_true;
            r_e_st  <= !w_p_true;
            r_state <= S_B_ISS;
          end else if (w_tmo) begin
            r_res   <= '1;
            r_rd    <= 1'b1;
            r_p_st  <= 1'b0;
            r_t_st  <= 1'b0;
            r_e_st  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_B_ISS: begin
          r_t_st  <= 1'b0;
          r_e_st  <= 1'b0;
          r_state <= S_B_WAIT;
        end
        S_B_WAIT: begin
          if (w_br_rd) begin
            r_res   <= w_br_res;
            r_rd    <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            r_res   <= '1;
            r_rd    <= 1'b1;
            r_p_st  <= 1'b0;
            r_t_st  <= 1'b0;
            r_e_st  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_rd    <= 1'b1;
          r_p_st  <= 1'b0;
          r_t_st  <= 1'b0;
          r_e_st  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign RD   = r_rd;
  assign RES  = r_res;
  assign ARG1 = r_arg1;
  assign ARG2 = r_arg2;
  assign ARG3 = r_arg3;
  assign P_ST = r_p_st;
  assign T_ST = r_t_st;
  assign E_ST = r_e_st;
  assign COND = r_cond;

endmodule

// File: tb/tb_composition_if_ctrl.sv
// Randomized bench for composition_if_ctrl with three behavioural callees of configurable busy time.
// Define COMPOSITION_IF_TIMEOUT_EN to also exercise the watchdog with TMO=8.
module tb_composition_if_ctrl;

  logic        clk;
  logic        rst;
  logic        st;
  logic        rd;
  logic [15:0] res;
  logic [15:0] in1, in2, in3;
  logic [15:0] arg1, arg2, arg3;
  logic        p_st, t_st, e_st;
  logic        p_rd, t_rd, e_rd;
  logic [15:0] p_res, t_res, e_res;
  logic        cond;
  logic        err;

  // Callee index 0 = predicate p, 1 = then-branch f, 2 = else-branch g.
  logic [2:0]  c_st;
  logic        c_rd    [3];
  logic [15:0] c_res   [3];
  logic [15:0] c_val   [3];
  int          c_cnt   [3];
  int          c_busy  [3];
  bit          c_stuck [3];

  int n_chk  = 0;
  int n_pass = 0;
  int n_p = 0, n_t = 0, n_e = 0, n_multi = 0;

`ifdef COMPOSITION_IF_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  composition_if_ctrl #(.W(16), .TMO(TMO)) dut (
    .CLK(clk), .RST(rst), .ST(st), .RD(rd), .RES(res),
    .IN1(in1), .IN2(in2), .IN3(in3),
    .ARG1(arg1), .ARG2(arg2), .ARG3(arg3),
    .P_ST(p_st), .P_RD(p_rd), .P_RES(p_res),
    .T_ST(t_st), .T_RD(t_rd), .T_RES(t_res),
    .E_ST(e_st), .E_RD(e_rd), .E_RES(e_res),
    .COND(cond), .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign c_st  = {e_st, t_st, p_st};
  assign p_rd  = c_rd[0];
  assign t_rd  = c_rd[1];
  assign e_rd  = c_rd[2];
  assign p_res = c_res[0];
  assign t_res = c_res[1];
  assign e_res = c_res[2];

  // Callee: RD drops on its accepting edge and rises c_busy edges later with its result.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        c_rd[k]  <= 1'b1;
        c_cnt[k] <= 0;
        c_res[k] <= '0;
      end else if (c_st[k] && c_rd[k]) begin
        c_rd[k]  <= 1'b0;
        c_cnt[k] <= c_busy[k];
      end else if (!c_rd[k] && !c_stuck[k]) begin
        if (c_cnt[k] <= 1) begin
          c_rd[k]  <= 1'b1;
          c_res[k] <= c_val[k];
        end else begin
          c_cnt[k] <= c_cnt[k] - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (p_st) n_p <= n_p + 1;
    if (t_st) n_t <= n_t + 1;
    if (e_st) n_e <= n_e + 1;
    if (int'(p_st) + int'(t_st) + int'(e_st) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One complete run; expectations come from the IF rule and the callee busy times.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [15:0] pr, input logic [15:0] tr, input logic [15:0] er,
                     input int bp, input int bb, input bit xst);
    int          edges;
    int          sp, stt, se, sm;
    bit          exp_cond;
    logic [15:0] exp_res;
    exp_cond  = (pr != 16'd0);
    exp_res   = exp_cond ? tr : er;
    c_val[0]  = pr;
    c_val[1]  = tr;
    c_val[2]  = er;
    c_busy[0] = bp;
    c_busy[1] = bb;
    c_busy[2] = bb;
    sp = n_p; stt = n_t; se = n_e; sm = n_multi;
    @(negedge clk);
    in1 = a; in2 = b; in3 = c;
    st  = 1'b1;
    @(posedge clk);
    #1;
    st  = 1'b0;
    in1 = 16'($urandom); in2 = 16'($urandom); in3 = 16'($urandom);
    chk("rd_busy", rd, 0);
    edges = 0;
    while (!rd && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
      st = xst && (edges == 3 || edges == 6);
    end
    st = 1'b0;
    chk("latency", edges, bp + bb + 4);
    chk("rd_done", rd, 1);
    chk("res", res, exp_res);
    chk("cond", cond, exp_cond);
    chk("arg1", arg1, a);
    chk("arg2", arg2, b);
    chk("arg3", arg3, c);
    chk("p_pulses", n_p - sp, 1);
    chk("t_pulses", n_t - stt, exp_cond ? 1 : 0);
    chk("e_pulses", n_e - se, exp_cond ? 0 : 1);
    chk("st_overlap", n_multi - sm, 0);
    chk("err_clear", err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int edges;
    rst = 1'b1; st = 1'b0;
    in1 = '0; in2 = '0; in3 = '0;
    for (int k = 0; k < 3; k++) begin
      c_val[k] = '0; c_busy[k] = 3; c_stuck[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", rd, 1);
    chk("rst_res", res, 0);
    chk("rst_p_st", p_st, 0);
    chk("rst_t_st", t_st, 0);
    chk("rst_e_st", e_st, 0);
    chk("rst_cond", cond, 0);
    chk("rst_arg1", arg1, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    run(16'd5, 16'd6, 16'd7, 16'd1, 16'h00AA, 16'h0055, 3, 3, 1'b0);
    run(16'd5, 16'd6, 16'd7, 16'd0, 16'h00AA, 16'h0055, 3, 3, 1'b0);
    run(16'd9, 16'd8, 16'd4, 16'h8000, 16'h1234, 16'h4321, 3, 4, 1'b1);

    for (int i = 0; i < 20; i++) begin
      int bp, bb;
      bit xst;
      logic [15:0] pr;
      bp  = $urandom_range(1, 6);
      bb  = $urandom_range(1, 6);
      xst = (bp >= 3 && bb >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      pr  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'd0;
      run(16'($urandom), 16'($urandom), 16'($urandom), pr,
          16'($urandom), 16'($urandom), bp, bb, xst);
    end

    // Reset while the then-branch is busy.
    c_val[0] = 16'd3; c_val[1] = 16'h7777; c_busy[0] = 2; c_busy[1] = 5;
    @(negedge clk);
    in1 = 16'd1; in2 = 16'd2; in3 = 16'd3;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    edges = 0;
    while (!t_st && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("t_st_seen", t_st, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rd", rd, 1);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_t_st", t_st, 0);
    chk("mid_rst_cond", cond, 0);
    @(negedge clk);
    rst = 1'b0;
    run(16'd11, 16'd12, 16'd13, 16'd2, 16'h0BEE, 16'h0DAD, 2, 3, 1'b0);

`ifdef COMPOSITION_IF_TIMEOUT_EN
    c_stuck[0] = 1'b1;
    c_busy[0]  = 2;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    edges = 0;
    while (!rd && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("tmo_latency", edges, TMO + 1);
    chk("tmo_rd", rd, 1);
    chk("tmo_err", err, 1);
    chk("tmo_res", res, 16'hFFFF);
    c_stuck[0] = 1'b0;
    edges = 0;
    while (!p_rd && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("p_recovered", p_rd, 1);
    run(16'd21, 16'd22, 16'd23, 16'd0, 16'h0101, 16'h0202, 3, 3, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
